// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder among NUM_REQ requesters.
// Grants are combinational; results return three cycles after the transfer.
module adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]    req_a,
   input  logic [NUM_REQ*DATA_W-1:0]    req_b,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         add_in_valid,
   output logic [DATA_W-1:0]            add_data_in0,
   output logic [DATA_W-1:0]            add_data_in1,
   input  logic [DATA_W:0]              add_data_out,
   input  logic                         add_out_valid,
   output logic                         rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [DATA_W:0]              rsp_data,
   output logic                         busy,
   output logic                         err
);
   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   ptr_reg, ptr_next;
   logic [ID_W-1:0]   grant_id;
   logic              grant_found;
   logic [ID_W:0]     cand;
   logic              in_flight_next;

   logic              in_valid_reg;
   logic [DATA_W-1:0] in0_reg, in1_reg;
   logic              tag_v_reg  [2];
   logic [ID_W-1:0]   tag_id_reg [2];
   logic              rsp_valid_reg;
   logic [ID_W-1:0]   rsp_id_reg;
   logic [DATA_W:0]   rsp_data_reg;
   logic              err_reg;
   logic [1:0]        ignore_reg;

   logic [DATA_W-1:0] a_arr [NUM_REQ];
   logic [DATA_W-1:0] b_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
         assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // First valid requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = '0;
      req_ready   = '0;
      if (enable && !rst) begin
         for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_reg} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(NUM_REQ))
               cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
               grant_found = 1'b1;
               grant_id    = cand[ID_W-1:0];
            end
         end
      end
      if (grant_found)
         req_ready[grant_id] = 1'b1;
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (grant_found)
         ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
   end

   // Busy must cover the response cycle, so look one cycle ahead.
   assign in_flight_next = grant_found | tag_v_reg[0] | tag_v_reg[1];

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_found) state_next = RUN;
         RUN: begin
            if (!in_flight_next)  state_next = IDLE;
            else if (!enable)     state_next = DRAIN;
         end
         DRAIN: begin
            if (!in_flight_next)            state_next = IDLE;
            else if (enable && grant_found) state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         in_valid_reg  <= 1'b0;
         in0_reg       <= '0;
         in1_reg       <= '0;
         tag_v_reg[0]  <= 1'b0;
         tag_v_reg[1]  <= 1'b0;
         tag_id_reg[0] <= '0;
         tag_id_reg[1] <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_data_reg  <= '0;
         err_reg       <= 1'b0;
         ignore_reg    <= 2'd2;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         in_valid_reg  <= grant_found;
         in0_reg       <= grant_found ? a_arr[grant_id] : '0;
         in1_reg       <= grant_found ? b_arr[grant_id] : '0;
         tag_v_reg[0]  <= grant_found;
         tag_id_reg[0] <= grant_id;
         tag_v_reg[1]  <= tag_v_reg[0];
         tag_id_reg[1] <= tag_id_reg[0];
         rsp_valid_reg <= add_out_valid && tag_v_reg[1];
         rsp_id_reg    <= (add_out_valid && tag_v_reg[1]) ? tag_id_reg[1] : '0;
         rsp_data_reg  <= (add_out_valid && tag_v_reg[1]) ? add_data_out : '0;
         // Results from ops killed by reset may still arrive right after release.
         if (ignore_reg != 2'd0)
            ignore_reg <= ignore_reg - 2'd1;
         else if (add_out_valid != tag_v_reg[1])
            err_reg <= 1'b1;
      end
   end

   assign add_in_valid = in_valid_reg;
   assign add_data_in0 = in0_reg;
   assign add_data_in1 = in1_reg;
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_id       = rsp_id_reg;
   assign rsp_data     = rsp_data_reg;
   assign busy         = (state_reg != IDLE);
   assign err          = err_reg;
endmodule
